instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_3000, meaning the byte address of instruction word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the instruction memory size in 32-bit words (power of two).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pc_addr  in  32  byte address of the requested instruction, from the PC register.
REQ-007 pc_valid  in  1  request strobe; accepted only when pc_ready=1.
REQ-008 pc_ready  out  1  high exactly when the state is IDLE.
REQ-009 flush  in  1  cancels any outstanding request (branch redirect).
REQ-010 instr  out  32  fetched instruction word.
REQ-011 instr_valid  out  1  instr/instr_exc valid; held until consumed.
REQ-012 instr_ready  in  1  consumer accepts the response.
REQ-013 instr_exc  out  1  address fault (misaligned or out of range).
REQ-014 mem_req  out  1  memory read request.
REQ-015 mem_addr  out  log2(DEPTH_WORDS)  word index = (pc_addr - BASE_ADDR) >> 2.
REQ-016 mem_ack  in  1  read data valid on mem_rdata this cycle.
REQ-017 mem_rdata  in  32  memory read data.

Function
REQ-018 The state machine SHALL have states IDLE, REQ, DROP and RESP.
REQ-019 IDLE with pc_valid=1 and flush=0: the block SHALL latch pc_addr.
REQ-020 IDLE: pc_addr[1:0]!=0, pc_addr<BASE_ADDR or pc_addr>=BASE_ADDR+4*DEPTH_WORDS SHALL cause a move to RESP with instr=0, instr_exc=1 and no mem_req.
REQ-021 IDLE, legal address (no hit): the block SHALL move to REQ, with mem_req=1 and mem_addr valid from the next cycle.
REQ-022 REQ: mem_req and mem_addr SHALL stay stable until mem_ack=1 is sampled; the block SHALL then capture mem_rdata into instr, set instr_exc=0, move to RESP, and drop mem_req on the following cycle.
REQ-023 Miss latency: pc_valid accepted at edge T, ack at edge T+1+k SHALL give instr_valid=1 after edge T+2+k.
REQ-024 RESP: instr_valid SHALL be 1 and instr and instr_exc SHALL be stable; instr_valid&instr_ready SHALL cause a move to IDLE (no new request in the same cycle).
REQ-025 flush in REQ: the block SHALL move to DROP and keep mem_req asserted until mem_ack, then discard the data and move to IDLE; flush coinciding with mem_ack SHALL go directly to IDLE.
REQ-026 flush in RESP SHALL clear instr_valid and go to IDLE; flush in IDLE SHALL block acceptance that cycle.
REQ-027 mem_ack in IDLE or RESP SHALL be ignored.
REQ-028 An address computation of BASE_ADDR+4*DEPTH_WORDS SHALL NOT wrap: a limit of 2^32 means there is no upper fault.

Reset
REQ-029 On reset the block SHALL enter IDLE and clear instr, instr_valid, instr_exc, mem_req, mem_addr and the hit-buffer valid bit, regardless of the current state.
REQ-030 Reset during REQ SHALL abandon the transaction, and a later mem_ack SHALL be ignored.

Configuration
REQ-031 Macro IFETCH_LAST_HIT_EN defined: the block SHALL hold a one-entry buffer (address, data, valid) written on every successful non-flushed memory response.
REQ-032 With the buffer, if the latched request matches a valid buffer address in IDLE, the block SHALL go to RESP with the buffered data at edge T+1, without mem_req.
REQ-033 Without the macro, every legal request SHALL go through REQ and no buffer storage SHALL exist.

Verification
REQ-034 Bench: reset, pc_addr=32'h3000, pc_valid, ack after 2 cycles with rdata=32'h3C01_1234 -> mem_addr=0, instr=32'h3C01_1234, instr_valid held until instr_ready, instr_exc=0.
REQ-035 Bench: pc_addr=32'h3002, then 32'h2FFC, then 32'h7000 -> each gives instr_valid at T+1 with instr=0, instr_exc=1, mem_req never high.
REQ-036 Bench: flush in REQ, ack 3 cycles later -> mem_req stays high until ack, no instr_valid, pc_ready returns after ack.
REQ-037 Bench: reset asserted in REQ, then a stray mem_ack -> all outputs zero, IDLE, ack ignored.
REQ-038 Bench: with IFETCH_LAST_HIT_EN, fetch 32'h6FFC twice -> mem_addr=12'hFFF on the first fetch, the second gives a 1-cycle hit with identical instr and no mem_req; without the macro, both fetches assert mem_req.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit between PC register and instruction memory
// Optional one-entry last-hit buffer enabled by defining IFETCH_LAST_HIT_EN.
module instr_fetch #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [31:0]                    pc_addr_i,
  input  logic                           pc_valid_i,
  output logic                           pc_ready_o,
  input  logic                           flush_i,
  output logic [31:0]                    instr_o,
  output logic                           instr_valid_o,
  input  logic                           instr_ready_i,
  output logic                           instr_exc_o,
  output logic                           mem_req_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
  input  logic                           mem_ack_i,
  input  logic [31:0]                    mem_rdata_i
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Computed in 33 bits so a window ending exactly at 2^32 has no upper fault.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {IDLE, REQ, DROP, RESP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic            exc_q, exc_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            addr_fault;
  logic [AW-1:0]   word_idx;

`ifdef IFETCH_LAST_HIT_EN
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     buf_addr_q, buf_addr_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic            buf_valid_q, buf_valid_d;
  logic            buf_hit;

  assign buf_hit = buf_valid_q && (buf_addr_q == pc_addr_i);
`endif

  assign addr_fault = (pc_addr_i[1:0] != 2'b00) ||
                      ({1'b0, pc_addr_i} < {1'b0, BASE_ADDR}) ||
                      ({1'b0, pc_addr_i} >= LIMIT);
  assign word_idx   = AW'((pc_addr_i - BASE_ADDR) >> 2);

  assign pc_ready_o    = (state_q == IDLE);
  assign instr_valid_o = (state_q == RESP);
  assign mem_req_o     = (state_q == REQ) || (state_q == DROP);
  assign instr_o       = instr_q;
  assign instr_exc_o   = exc_q;
  assign mem_addr_o    = mem_addr_q;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      exc_q       <= 1'b0;
      mem_addr_q  <= '0;
`ifdef IFETCH_LAST_HIT_EN
      req_addr_q  <= '0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      exc_q       <= exc_d;
      mem_addr_q  <= mem_addr_d;
`ifdef IFETCH_LAST_HIT_EN
      req_addr_q  <= req_addr_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

  // Next-state: accept/decode in IDLE, wait for ack in REQ/DROP, hold response in RESP.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    exc_d       = exc_q;
    mem_addr_d  = mem_addr_q;
`ifdef IFETCH_LAST_HIT_EN
    req_addr_d  = req_addr_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (pc_valid_i && !flush_i) begin
`ifdef IFETCH_LAST_HIT_EN
          req_addr_d = pc_addr_i;
`endif
          if (addr_fault) begin
            state_d = RESP;
            instr_d = '0;
            exc_d   = 1'b1;
          end
`ifdef IFETCH_LAST_HIT_EN
          else if (buf_hit) begin
            state_d = RESP;
            instr_d = buf_data_q;
            exc_d   = 1'b0;
          end
`endif
          else begin
            state_d    = REQ;
            mem_addr_d = word_idx;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            instr_d = mem_rdata_i;
            exc_d   = 1'b0;
`ifdef IFETCH_LAST_HIT_EN
            buf_addr_d  = req_addr_q;
            buf_data_d  = mem_rdata_i;
            buf_valid_d = 1'b1;
`endif
          end
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (flush_i || instr_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        instr_exc;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] fault_addrs [3];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .pc_addr_i     (pc_addr),
    .pc_valid_i    (pc_valid),
    .pc_ready_o    (pc_ready),
    .flush_i       (flush),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_exc_o   (instr_exc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_addr = '0; pc_valid = 1'b0; flush = 1'b0;
    instr_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    fault_addrs[0] = 32'h0000_3002;
    fault_addrs[1] = 32'h0000_2FFC;
    fault_addrs[2] = 32'h0000_7000;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pc_ready", 32'(pc_ready), 32'd1);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_exc", 32'(instr_exc), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);

    // Miss at word 0, ack after two cycles
    pc_addr = 32'h0000_3000; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("miss_req", 32'(mem_req), 32'd1);
    chk("miss_addr", 32'(mem_addr), 32'd0);
    chk("miss_busy", 32'(pc_ready), 32'd0);
    tick();
    chk("miss_req_hold", 32'(mem_req), 32'd1);
    chk("miss_novalid", 32'(instr_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h3C01_1234;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    chk("miss_valid", 32'(instr_valid), 32'd1);
    chk("miss_instr", instr, 32'h3C01_1234);
    chk("miss_exc", 32'(instr_exc), 32'd0);
    chk("miss_req_drop", 32'(mem_req), 32'd0);
    tick();
    chk("miss_hold_valid", 32'(instr_valid), 32'd1);
    chk("miss_hold_instr", instr, 32'h3C01_1234);
    consume();
    chk("miss_done", 32'(instr_valid), 32'd0);
    chk("miss_idle", 32'(pc_ready), 32'd1);

    // Address faults: misaligned, below base, at upper limit
    for (int i = 0; i < 3; i++) begin
      pc_addr = fault_addrs[i]; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      chk("flt_valid", 32'(instr_valid), 32'd1);
      chk("flt_instr", instr, 32'd0);
      chk("flt_exc", 32'(instr_exc), 32'd1);
      chk("flt_req", 32'(mem_req), 32'd0);
      consume();
      chk("flt_req_after", 32'(mem_req), 32'd0);
      chk("flt_idle", 32'(pc_ready), 32'd1);
    end

    // Flush in IDLE blocks acceptance
    pc_addr = 32'h0000_3004; pc_valid = 1'b1; flush = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b0;
    chk("flidle_ready", 32'(pc_ready), 32'd1);
    chk("flidle_req", 32'(mem_req), 32'd0);

    // Flush in REQ, ack three cycles later
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("flreq_addr", 32'(mem_addr), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drop_req", 32'(mem_req), 32'd1);
    chk("drop_busy", 32'(pc_ready), 32'd0);
    tick();
    chk("drop_req2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    chk("drop_novalid", 32'(instr_valid), 32'd0);
    chk("drop_ready", 32'(pc_ready), 32'd1);
    chk("drop_req_off", 32'(mem_req), 32'd0);

    // Flush coinciding with ack goes straight to IDLE
    pc_addr = 32'h0000_300C; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    flush = 1'b1; mem_ack = 1'b1;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    chk("flack_ready", 32'(pc_ready), 32'd1);
    chk("flack_valid", 32'(instr_valid), 32'd0);
    chk("flack_req", 32'(mem_req), 32'd0);

    // Reset during REQ, stray ack afterwards
    pc_addr = 32'h0000_3008; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("rreq_addr", 32'(mem_addr), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("rreq_ready", 32'(pc_ready), 32'd1);
    chk("rreq_valid", 32'(instr_valid), 32'd0);
    chk("rreq_req", 32'(mem_req), 32'd0);
    chk("rreq_instr", instr, 32'd0);
    chk("rreq_exc", 32'(instr_exc), 32'd0);
    chk("rreq_maddr", 32'(mem_addr), 32'd0);

    // Last word of memory, fetched twice
    pc_addr = 32'h0000_6FFC; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("top_addr", 32'(mem_addr), 32'h0000_0FFF);
    chk("top_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick();
    mem_ack = 1'b0;
    chk("top_instr", instr, 32'hA5A5_0001);
    consume();
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
`ifdef IFETCH_LAST_HIT_EN
    chk("hit_valid", 32'(instr_valid), 32'd1);
    chk("hit_req", 32'(mem_req), 32'd0);
    chk("hit_instr", instr, 32'hA5A5_0001);
    chk("hit_exc", 32'(instr_exc), 32'd0);
`else
    chk("nohit_req", 32'(mem_req), 32'd1);
    chk("nohit_valid", 32'(instr_valid), 32'd0);
    chk("nohit_addr", 32'(mem_addr), 32'h0000_0FFF);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick();
    mem_ack = 1'b0;
    chk("nohit_instr", instr, 32'hA5A5_0001);
`endif
    consume();
    chk("end_idle", 32'(pc_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
